// File: rtl/vx_tma_mem_arbiter.sv
// LSU/TMA local-memory arbiter: one-entry request stage (1-cycle latency), zero-latency response routing by tag MSB.
// Backpressure: reqN_ready only for the granted source when the stage can accept; `TMA_ARB_PERF_EN adds stall counters.
module vx_tma_mem_arbiter #(
  parameter int NUM_LANES   = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16,
  parameter int MAX_WAIT    = 8
) (
  input  logic                            clk,
  input  logic                            reset,

  input  logic                            req0_valid,
  output logic                            req0_ready,
  input  logic                            req0_rw,
  input  logic [NUM_LANES-1:0]            req0_mask,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] req0_addr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] req0_data,
  input  logic [TAG_WIDTH-1:0]            req0_tag,
  output logic                            rsp0_valid,
  input  logic                            rsp0_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] rsp0_data,
  output logic [TAG_WIDTH-1:0]            rsp0_tag,

  input  logic                            req1_valid,
  output logic                            req1_ready,
  input  logic                            req1_rw,
  input  logic [NUM_LANES-1:0]            req1_mask,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] req1_addr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] req1_data,
  input  logic [TAG_WIDTH-1:0]            req1_tag,
  output logic                            rsp1_valid,
  input  logic                            rsp1_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] rsp1_data,
  output logic [TAG_WIDTH-1:0]            rsp1_tag,

  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic                            mem_req_rw,
  output logic [NUM_LANES-1:0]            mem_req_mask,
  output logic [NUM_LANES*ADDR_WIDTH-1:0] mem_req_addr,
  output logic [NUM_LANES*DATA_WIDTH-1:0] mem_req_data,
  output logic [TAG_WIDTH:0]              mem_req_tag,

  input  logic                            mem_rsp_valid,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] mem_rsp_data,
  input  logic [TAG_WIDTH:0]              mem_rsp_tag,
  output logic                            mem_rsp_ready,

  input  logic                            drain_req,
  output logic                            drain_done
`ifdef TMA_ARB_PERF_EN
  ,
  output logic [31:0]                     perf_tma_stall_cycles,
  output logic [31:0]                     perf_lsu_stall_cycles
`endif
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] S_NORMAL = 2'd0;
  localparam logic [1:0] S_BOOST  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  typedef struct packed {
    logic                            rw;
    logic [NUM_LANES-1:0]            mask;
    logic [NUM_LANES*ADDR_WIDTH-1:0] addr;
    logic [NUM_LANES*DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH:0]              tag;
  } mreq_t;

  logic [1:0]    state, state_nxt;
  logic [PW-1:0] pend0, pend1, pend0_nxt, pend1_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          stage_vld, stage_vld_nxt;
  mreq_t         stage_q, req0_pkt, req1_pkt;

  logic can_accept, elig0, elig1, gnt0, gnt1, fire0, fire1;
  logic rsp_sel, rsp0_fire, rsp1_fire;

  assign req0_pkt = '{rw: req0_rw, mask: req0_mask, addr: req0_addr, data: req0_data,
                      tag: {1'b0, req0_tag}};
  assign req1_pkt = '{rw: req1_rw, mask: req1_mask, addr: req1_addr, data: req1_data,
                      tag: {1'b1, req1_tag}};

  // Elastic stage: accepts whenever it is empty or its entry leaves this cycle.
  assign can_accept = ~stage_vld | mem_req_ready;

  assign elig0 = req0_valid & (req0_rw | (pend0 < PW'(MAX_PENDING))) & (state != S_DRAIN);
  assign elig1 = req1_valid & (req1_rw | (pend1 < PW'(MAX_PENDING))) & (state != S_DRAIN);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      S_NORMAL: begin
        gnt0 = elig0;
        gnt1 = elig1 & ~elig0;
      end
      S_BOOST: begin
        gnt1 = elig1;
        gnt0 = elig0 & ~elig1;
      end
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

  // Handshake outputs are forced low while reset is held so they drop immediately.
  assign req0_ready = gnt0 & can_accept & ~reset;
  assign req1_ready = gnt1 & can_accept & ~reset;
  assign fire0      = req0_valid & req0_ready;
  assign fire1      = req1_valid & req1_ready;

  assign stage_vld_nxt = can_accept ? (fire0 | fire1) : stage_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_vld <= 1'b0;
      stage_q   <= '0;
    end else begin
      stage_vld <= stage_vld_nxt;
      if (fire1)
        stage_q <= req1_pkt;
      else if (fire0)
        stage_q <= req0_pkt;
    end
  end

  assign mem_req_valid = stage_vld;
  assign mem_req_rw    = stage_q.rw;
  assign mem_req_mask  = stage_q.mask;
  assign mem_req_addr  = stage_q.addr;
  assign mem_req_data  = stage_q.data;
  assign mem_req_tag   = stage_q.tag;

  assign rsp_sel       = mem_rsp_tag[TAG_WIDTH];
  assign rsp0_valid    = mem_rsp_valid & ~rsp_sel & ~reset;
  assign rsp1_valid    = mem_rsp_valid &  rsp_sel & ~reset;
  assign rsp0_data     = mem_rsp_data;
  assign rsp1_data     = mem_rsp_data;
  assign rsp0_tag      = mem_rsp_tag[TAG_WIDTH-1:0];
  assign rsp1_tag      = mem_rsp_tag[TAG_WIDTH-1:0];
  assign mem_rsp_ready = ~reset & (rsp_sel ? rsp1_ready : rsp0_ready);
  assign rsp0_fire     = rsp0_valid & rsp0_ready;
  assign rsp1_fire     = rsp1_valid & rsp1_ready;

  // A stray response on an idle source is held at zero rather than wrapping.
  function automatic logic [PW-1:0] pend_upd(input logic [PW-1:0] p, input logic inc,
                                             input logic dec);
    if (inc && !dec)
      return p + PW'(1);
    else if (dec && !inc && (p != '0))
      return p - PW'(1);
    else
      return p;
  endfunction

  assign pend0_nxt = pend_upd(pend0, fire0 & ~req0_rw, rsp0_fire);
  assign pend1_nxt = pend_upd(pend1, fire1 & ~req1_rw, rsp1_fire);

  always_comb begin
    wait_nxt = wait_cnt;
    if (fire1)
      wait_nxt = '0;
    else if (elig1 && (wait_cnt < WW'(MAX_WAIT)))
      wait_nxt = wait_cnt + WW'(1);
  end

  // Entering BOOST on the saturating increment lets TMA win on the very next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_NORMAL: if (wait_nxt == WW'(MAX_WAIT)) state_nxt = S_BOOST;
      S_BOOST:  if (fire1) state_nxt = S_NORMAL;
      S_DRAIN:  if (!drain_req) state_nxt = S_NORMAL;
      default:  state_nxt = S_NORMAL;
    endcase
    if (drain_req)
      state_nxt = S_DRAIN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_NORMAL;
      pend0      <= '0;
      pend1      <= '0;
      wait_cnt   <= '0;
      drain_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend0      <= pend0_nxt;
      pend1      <= pend1_nxt;
      wait_cnt   <= wait_nxt;
      drain_done <= (state_nxt == S_DRAIN) && (pend0_nxt == '0) && (pend1_nxt == '0) &&
                    !stage_vld_nxt;
    end
  end

`ifdef TMA_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_tma_stall_cycles <= '0;
      perf_lsu_stall_cycles <= '0;
    end else begin
      if (req1_valid && !req1_ready)
        perf_tma_stall_cycles <= perf_tma_stall_cycles + 32'd1;
      if (req0_valid && !req0_ready)
        perf_lsu_stall_cycles <= perf_lsu_stall_cycles + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_rsp0_no_pending: assert property (@(posedge clk) disable iff (reset)
    !(rsp0_fire && (pend0 == '0)));
  a_rsp1_no_pending: assert property (@(posedge clk) disable iff (reset)
    !(rsp1_fire && (pend1 == '0)));
`endif

endmodule
